// File: rtl/williams2_rom_pkg.sv
// Shared constants and types for the Williams-2 ROM download path.
// Holds the ioctl address map (region base/limit), the expected byte count
// of a complete ROM set, and the loader/region enumerations.
package williams2_rom_pkg;

  // ioctl byte-address map; everything above DEC_LIMIT is out-of-map.
  localparam logic [16:0] MAIN_BASE  = 17'h00000;
  localparam logic [16:0] MAIN_LIMIT = 17'h0FFFF;
  localparam logic [16:0] SND_BASE   = 17'h10000;
  localparam logic [16:0] SND_LIMIT  = 17'h10FFF;
  localparam logic [16:0] GFX_BASE   = 17'h11000;
  localparam logic [16:0] GFX_LIMIT  = 17'h12FFF;
  localparam logic [16:0] DEC_BASE   = 17'h13000;
  localparam logic [16:0] DEC_LIMIT  = 17'h131FF;

  // Byte count of a complete, good ROM set.
  localparam logic [16:0] EXP_BYTES  = 17'h13200;

  // Byte counter saturation value.
  localparam logic [16:0] CNT_MAX    = 17'h1FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_READY,
    ST_ERROR
  } loader_state_t;

  typedef enum logic [2:0] {
    RGN_MAIN,
    RGN_SND,
    RGN_GFX,
    RGN_DEC,
    RGN_NONE
  } rom_region_t;

endpackage

// File: rtl/rom_region_decode.sv
// Combinational ioctl address decoder.
// Ports:
//   addr   - 17-bit ioctl byte address
//   region - region the address falls in (RGN_NONE when out-of-map)
//   offset - address relative to the region base, 16 bits
module rom_region_decode
  import williams2_rom_pkg::*;
(
  input  logic [16:0]  addr,
  output rom_region_t  region,
  output logic [15:0]  offset
);

  logic [16:0] base;

  always_comb begin
    region = RGN_NONE;
    base   = '0;
    if (addr <= MAIN_LIMIT) begin
      region = RGN_MAIN;
      base   = MAIN_BASE;
    end else if (addr <= SND_LIMIT) begin
      region = RGN_SND;
      base   = SND_BASE;
    end else if (addr <= GFX_LIMIT) begin
      region = RGN_GFX;
      base   = GFX_BASE;
    end else if (addr <= DEC_LIMIT) begin
      region = RGN_DEC;
      base   = DEC_BASE;
    end
  end

  // All bases are below 2^16 apart from bit 16, so a 16-bit subtract on the
  // low halves gives the truncated region-relative offset directly.
  always_comb begin
    offset = addr[15:0] - base[15:0];
  end

  logic unused_base_msb;
  always_comb unused_base_msb = base[16];

endmodule

// File: rtl/ioctl_rom_loader.sv
// HPS ioctl ROM download sequencer.
// Accepts a download on ROM_INDEX, splits the byte stream into MAIN/SND/GFX/DEC
// write strobes with region-relative addresses, counts every strobed byte,
// keeps a modulo-256 checksum of in-map bytes, and verifies the total count
// when the download ends. The game core is held in reset until a load passes.
// Ports:
//   clk_sys, reset                       - 12 MHz clock, sync active-high reset
//   ioctl_download/index/wr/addr/dout    - HPS download interface
//   rom_addr, rom_data                   - registered write address/data
//   main_we, snd_we, gfx_we, dec_we      - one-cycle region write enables
//   core_reset                           - hold game core in reset
//   rom_loaded, load_error               - result of the last load
//   checksum                             - sum of accepted in-map bytes
module ioctl_rom_loader #(
  parameter logic [16:0] EXP_BYTES = williams2_rom_pkg::EXP_BYTES,
  parameter logic [7:0]  ROM_INDEX = 8'd0
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [16:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [15:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        main_we,
  output logic        snd_we,
  output logic        gfx_we,
  output logic        dec_we,
  output logic        core_reset,
  output logic        rom_loaded,
  output logic        load_error,
  output logic [7:0]  checksum
);

  import williams2_rom_pkg::*;

  loader_state_t state_q;
  loader_state_t state_d;

  rom_region_t   region;
  logic [15:0]   offset;
  logic [16:0]   byte_cnt;
  logic          start_load;
  logic          load_entry;
  logic          accept_wr;

  rom_region_decode u_decode (
    .addr   (ioctl_addr),
    .region (region),
    .offset (offset)
  );

  always_comb begin
    start_load = ioctl_download && (ioctl_index == ROM_INDEX);
    accept_wr  = (state_q == ST_LOAD) && ioctl_wr;
    load_entry = (state_q != ST_LOAD) && (state_d == ST_LOAD);
  end

  // State register
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_READY, ST_ERROR: begin
        if (start_load) state_d = ST_LOAD;
      end
      // Still in LOAD on the cycle download falls, so a strobe in that same
      // cycle is accepted by accept_wr before CHECK looks at the count.
      ST_LOAD: begin
        if (!ioctl_download) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        state_d = (byte_cnt == EXP_BYTES) ? ST_READY : ST_ERROR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs are pure functions of state: a new load leaves READY or
  // ERROR, which clears both result flags.
  always_comb begin
    core_reset = (state_q != ST_READY);
    rom_loaded = (state_q == ST_READY);
    load_error = (state_q == ST_ERROR);
  end

  // Write pipeline, byte counter and checksum.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      main_we  <= 1'b0;
      snd_we   <= 1'b0;
      gfx_we   <= 1'b0;
      dec_we   <= 1'b0;
      rom_addr <= '0;
      rom_data <= '0;
      byte_cnt <= '0;
      checksum <= '0;
    end else begin
      main_we <= 1'b0;
      snd_we  <= 1'b0;
      gfx_we  <= 1'b0;
      dec_we  <= 1'b0;
      if (accept_wr) begin
        if (byte_cnt != CNT_MAX) byte_cnt <= byte_cnt + 17'd1;
        if (region != RGN_NONE) begin
          rom_addr <= offset;
          rom_data <= ioctl_dout;
          checksum <= checksum + ioctl_dout;
        end
        case (region)
          RGN_MAIN: main_we <= 1'b1;
          RGN_SND:  snd_we  <= 1'b1;
          RGN_GFX:  gfx_we  <= 1'b1;
          RGN_DEC:  dec_we  <= 1'b1;
          default:  ;
        endcase
      end else if (load_entry) begin
        byte_cnt <= '0;
        checksum <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ioctl_rom_loader.sv
module tb_ioctl_rom_loader;

  localparam logic [16:0] SMALL_EXP = 17'h0040;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [16:0] ioctl_addr;
  logic [7:0]  ioctl_dout;

  logic [15:0] b_rom_addr, s_rom_addr;
  logic [7:0]  b_rom_data, s_rom_data, b_checksum, s_checksum;
  logic        b_main_we, b_snd_we, b_gfx_we, b_dec_we;
  logic        s_main_we, s_snd_we, s_gfx_we, s_dec_we;
  logic        b_core_reset, b_rom_loaded, b_load_error;
  logic        s_core_reset, s_rom_loaded, s_load_error;

  // Full-size instance (default count) and a short-count instance for the
  // many small loads; both see identical stimulus.
  ioctl_rom_loader u_big (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .rom_addr(b_rom_addr), .rom_data(b_rom_data),
    .main_we(b_main_we), .snd_we(b_snd_we), .gfx_we(b_gfx_we), .dec_we(b_dec_we),
    .core_reset(b_core_reset), .rom_loaded(b_rom_loaded),
    .load_error(b_load_error), .checksum(b_checksum)
  );

  ioctl_rom_loader #(.EXP_BYTES(SMALL_EXP), .ROM_INDEX(8'd0)) u_small (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .rom_addr(s_rom_addr), .rom_data(s_rom_data),
    .main_we(s_main_we), .snd_we(s_snd_we), .gfx_we(s_gfx_we), .dec_we(s_dec_we),
    .core_reset(s_core_reset), .rom_loaded(s_rom_loaded),
    .load_error(s_load_error), .checksum(s_checksum)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: one per instance. Result: 0 none, 1 passed, 2 failed.
  logic [16:0] exp_bytes [2];
  bit          m_loading [2];
  bit          m_checking[2];
  int          m_res     [2];
  logic [16:0] m_cnt     [2];
  int          m_sum     [2];
  logic [3:0]  m_we      [2];   // {dec, gfx, snd, main}
  logic [15:0] m_ra      [2];
  logic [7:0]  m_rd      [2];

  // Pulse counters for the full load on the big instance.
  bit count_en = 1'b0;
  int n_main = 0, n_snd = 0, n_gfx = 0, n_dec = 0;
  always @(negedge clk_sys) begin
    if (count_en) begin
      if (b_main_we) n_main++;
      if (b_snd_we)  n_snd++;
      if (b_gfx_we)  n_gfx++;
      if (b_dec_we)  n_dec++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic void ref_region(input logic [16:0] a, output logic [3:0] we,
                                     output logic [15:0] off);
    int ai;
    ai = int'(a);
    we = 4'b0000; off = 16'h0;
    if (ai < 'h10000)      begin we = 4'b0001; off = 16'(ai);           end
    else if (ai < 'h11000) begin we = 4'b0010; off = 16'(ai - 'h10000); end
    else if (ai < 'h13000) begin we = 4'b0100; off = 16'(ai - 'h11000); end
    else if (ai < 'h13200) begin we = 4'b1000; off = 16'(ai - 'h13000); end
  endfunction

  function automatic logic [38:0] dut_word(input int k, input logic [3:0] exp_we);
    logic [3:0] we; logic [15:0] ra; logic [7:0] rd, cs; logic cr, rl, le;
    if (k == 0) begin
      we = {b_dec_we, b_gfx_we, b_snd_we, b_main_we};
      ra = b_rom_addr; rd = b_rom_data; cs = b_checksum;
      cr = b_core_reset; rl = b_rom_loaded; le = b_load_error;
    end else begin
      we = {s_dec_we, s_gfx_we, s_snd_we, s_main_we};
      ra = s_rom_addr; rd = s_rom_data; cs = s_checksum;
      cr = s_core_reset; rl = s_rom_loaded; le = s_load_error;
    end
    if (exp_we == 4'b0000) begin ra = '0; rd = '0; end
    return {we, ra, rd, cs, cr, rl, le};
  endfunction

  function automatic logic [38:0] model_word(input int k);
    logic [15:0] ra; logic [7:0] rd;
    ra = (m_we[k] != 4'b0000) ? m_ra[k] : 16'h0;
    rd = (m_we[k] != 4'b0000) ? m_rd[k] : 8'h0;
    return {m_we[k], ra, rd, 8'(m_sum[k]), (m_res[k] != 1), (m_res[k] == 1), (m_res[k] == 2)};
  endfunction

  // One clock: drive inputs, advance the model, compare after the edge.
  task automatic step(input logic r, input logic dl, input logic [7:0] idx,
                      input logic w, input logic [16:0] a, input logic [7:0] d);
    logic [3:0] we; logic [15:0] off;
    reset = r; ioctl_download = dl; ioctl_index = idx;
    ioctl_wr = w; ioctl_addr = a; ioctl_dout = d;
    for (int k = 0; k < 2; k++) begin
      m_we[k] = 4'b0000;
      if (r) begin
        m_loading[k] = 0; m_checking[k] = 0; m_res[k] = 0;
        m_cnt[k] = '0; m_sum[k] = 0;
      end else if (m_loading[k]) begin
        if (w) begin
          if (m_cnt[k] != 17'h1FFFF) m_cnt[k] = m_cnt[k] + 17'd1;
          ref_region(a, we, off);
          if (we != 4'b0000) begin
            m_we[k] = we; m_ra[k] = off; m_rd[k] = d;
            m_sum[k] = (m_sum[k] + int'(d)) % 256;
          end
        end
        if (!dl) begin m_loading[k] = 0; m_checking[k] = 1; end
      end else if (m_checking[k]) begin
        m_checking[k] = 0;
        m_res[k] = (m_cnt[k] == exp_bytes[k]) ? 1 : 2;
      end else if (dl && idx == 8'd0) begin
        m_loading[k] = 1; m_cnt[k] = '0; m_sum[k] = 0; m_res[k] = 0;
      end
    end
    @(negedge clk_sys);
    check("outputs_big",   64'(dut_word(0, m_we[0])), 64'(model_word(0)));
    check("outputs_small", 64'(dut_word(1, m_we[1])), 64'(model_word(1)));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'd0, 0, '0, '0);
  endtask

  task automatic load_start();
    step(0, 1, 8'd0, 0, '0, '0);
  endtask

  task automatic wr_byte(input logic [16:0] a, input logic [7:0] d);
    step(0, 1, 8'd0, 1, a, d);
  endtask

  task automatic load_end();
    step(0, 0, 8'd0, 0, '0, '0);   // download low -> check
    step(0, 0, 8'd0, 0, '0, '0);   // result state
  endtask

  task automatic seq_load(input int n);
    load_start();
    for (int i = 0; i < n; i++) wr_byte(17'(i), 8'(i * 7 + 3));
    load_end();
  endtask

  function automatic logic [16:0] rand_addr();
    case ($urandom_range(0, 4))
      0: return 17'($urandom_range(0, 'hFFFF));
      1: return 17'('h10000 + $urandom_range(0, 'hFFF));
      2: return 17'('h11000 + $urandom_range(0, 'h1FFF));
      3: return 17'('h13000 + $urandom_range(0, 'h1FF));
      default: return 17'('h13200 + $urandom_range(0, 'hCDFF));
    endcase
  endfunction

  typedef struct {
    logic [16:0] addr;
    logic [7:0]  data;
    logic [3:0]  we;     // {dec, gfx, snd, main}
    logic [15:0] ra;
  } vec_t;

  vec_t vecs [12];

  initial begin
    logic [16:0] a;
    logic [7:0]  d;
    logic [3:0]  swe;
    int          n, rst_at;
    bit          do_rst, aborted, fell;

    vecs[0]  = '{17'h00000, 8'h11, 4'b0001, 16'h0000};
    vecs[1]  = '{17'h0FFFF, 8'h22, 4'b0001, 16'hFFFF};
    vecs[2]  = '{17'h10000, 8'h33, 4'b0010, 16'h0000};
    vecs[3]  = '{17'h10FFF, 8'h44, 4'b0010, 16'h0FFF};
    vecs[4]  = '{17'h11000, 8'h55, 4'b0100, 16'h0000};
    vecs[5]  = '{17'h11005, 8'hA5, 4'b0100, 16'h0005};
    vecs[6]  = '{17'h12FFF, 8'h66, 4'b0100, 16'h1FFF};
    vecs[7]  = '{17'h13000, 8'h77, 4'b1000, 16'h0000};
    vecs[8]  = '{17'h131FF, 8'h88, 4'b1000, 16'h01FF};
    vecs[9]  = '{17'h13200, 8'h99, 4'b0000, 16'h0000};
    vecs[10] = '{17'h1FFFF, 8'hAA, 4'b0000, 16'h0000};
    vecs[11] = '{17'h08000, 8'hBB, 4'b0001, 16'h8000};

    exp_bytes[0] = 17'h13200;
    exp_bytes[1] = SMALL_EXP;
    for (int k = 0; k < 2; k++) begin
      m_loading[k] = 0; m_checking[k] = 0; m_res[k] = 0;
      m_cnt[k] = '0; m_sum[k] = 0; m_we[k] = '0; m_ra[k] = '0; m_rd[k] = '0;
    end

    // Reset state
    step(1, 0, 8'd0, 0, '0, '0);
    step(1, 0, 8'd0, 0, '0, '0);
    check("reset_big",   64'({b_main_we, b_snd_we, b_gfx_we, b_dec_we, b_rom_addr, b_rom_data,
                              b_checksum, b_core_reset, b_rom_loaded, b_load_error}),
                         64'({4'b0, 16'h0, 8'h0, 8'h0, 1'b1, 1'b0, 1'b0}));
    check("reset_small", 64'({s_main_we, s_snd_we, s_gfx_we, s_dec_we, s_rom_addr, s_rom_data,
                              s_checksum, s_core_reset, s_rom_loaded, s_load_error}),
                         64'({4'b0, 16'h0, 8'h0, 8'h0, 1'b1, 1'b0, 1'b0}));
    idle(2);

    // Region boundary vectors
    load_start();
    foreach (vecs[i]) begin
      wr_byte(vecs[i].addr, vecs[i].data);
      swe = {s_dec_we, s_gfx_we, s_snd_we, s_main_we};
      check("vec_we", 64'(swe), 64'(vecs[i].we));
      if (vecs[i].we != 4'b0000)
        check("vec_addr_data", 64'({s_rom_addr, s_rom_data}), 64'({vecs[i].ra, vecs[i].data}));
    end
    load_end();
    check("vec_load_error", 64'({s_load_error, s_rom_loaded, s_core_reset}), 64'(3'b101));

    // Short load -> ERROR, then a correct load -> READY
    seq_load(int'(SMALL_EXP) - 1);
    check("short_error", 64'({s_load_error, s_rom_loaded, s_core_reset}), 64'(3'b101));
    seq_load(int'(SMALL_EXP));
    check("good_ready", 64'({s_load_error, s_rom_loaded, s_core_reset}), 64'(3'b010));

    // Foreign index download from READY: ignored
    step(0, 1, 8'd1, 0, '0, '0);
    for (int i = 0; i < 6; i++) step(0, 1, 8'd1, 1, 17'(i * 'h3000), 8'hC3);
    step(0, 0, 8'd1, 0, '0, '0);
    idle(2);
    check("foreign_idx_ready", 64'({s_load_error, s_rom_loaded, s_core_reset}), 64'(3'b010));

    // Extra out-of-map byte on an otherwise exact load -> ERROR
    load_start();
    for (int i = 0; i < int'(SMALL_EXP); i++) wr_byte(17'(i), 8'(i));
    wr_byte(17'h13200, 8'h5A);
    check("oob_no_we", 64'({s_main_we, s_snd_we, s_gfx_we, s_dec_we}), 64'(0));
    load_end();
    check("extra_error", 64'({s_load_error, s_rom_loaded, s_core_reset}), 64'(3'b101));

    // Reset at byte 0x800 with a strobe in the same cycle
    load_start();
    for (int i = 0; i < 'h800; i++) wr_byte(17'(i), 8'(i));
    step(1, 1, 8'd0, 1, 17'h00800, 8'hEE);
    check("rst_we_big",   64'({b_main_we, b_snd_we, b_gfx_we, b_dec_we}), 64'(0));
    check("rst_flags",    64'({b_core_reset, b_rom_loaded, b_load_error, b_checksum,
                               s_core_reset, s_rom_loaded, s_load_error, s_checksum}),
                          64'({1'b1, 1'b0, 1'b0, 8'h0, 1'b1, 1'b0, 1'b0, 8'h0}));
    idle(3);
    check("rst_stays_idle", 64'({s_rom_loaded, s_load_error, s_core_reset}), 64'(3'b001));

    // Randomized loads against the model
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 4) == 0) begin
        step(0, 1, 8'($urandom_range(1, 255)), 0, '0, '0);
        for (int j = 0; j < 4; j++) step(0, 1, 8'($urandom_range(1, 255)), 1, rand_addr(), 8'($urandom));
        idle(1);
      end
      n       = int'(SMALL_EXP) - 2 + $urandom_range(0, 4);
      do_rst  = ($urandom_range(0, 7) == 0);
      rst_at  = $urandom_range(0, n - 1);
      aborted = 0;
      fell    = 0;
      load_start();
      for (int j = 0; j < n && !aborted; j++) begin
        a = ($urandom_range(0, 9) == 0 && j > 0) ? ioctl_addr : rand_addr();
        d = 8'($urandom);
        if (do_rst && j == rst_at) begin
          step(1, 1, 8'd0, 1, a, d);
          idle(2);
          aborted = 1;
        end else begin
          fell = (j == n - 1) && ($urandom_range(0, 1) == 1);
          step(0, !fell, 8'd0, 1, a, d);
          if (!fell && $urandom_range(0, 3) == 0) step(0, 1, 8'd0, 0, '0, '0);
        end
      end
      if (!aborted) begin
        if (fell) idle(1);
        else load_end();
      end
      idle(1);
    end

    // Full load on the big instance; last strobe coincides with download falling
    n_main = 0; n_snd = 0; n_gfx = 0; n_dec = 0;
    count_en = 1'b1;
    load_start();
    for (int i = 0; i < 'h131FF; i++) wr_byte(17'(i), 8'(i));
    step(0, 0, 8'd0, 1, 17'h131FF, 8'hFF);
    idle(2);
    count_en = 1'b0;
    check("full_main_pulses", 64'(n_main), 64'('h10000));
    check("full_snd_pulses",  64'(n_snd),  64'('h1000));
    check("full_gfx_pulses",  64'(n_gfx),  64'('h2000));
    check("full_dec_pulses",  64'(n_dec),  64'('h200));
    check("full_ready", 64'({b_rom_loaded, b_load_error, b_core_reset}), 64'(3'b100));
    check("full_checksum", 64'(b_checksum), 64'(8'h00));
    check("full_small_error", 64'({s_load_error, s_core_reset}), 64'(2'b11));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ioctl_rom_loader.md
IOCTL_ROM_LOADER -- requirements
Module: ioctl_rom_loader

Interface
REQ-001 Parameter: EXP_BYTES, default 17'h13200, total byte count required for a good load.
REQ-002 Parameter: ROM_INDEX, default 8'd0, the ioctl_index value accepted as a ROM download.
REQ-003 clk_sys  in  1  system clock (12 MHz); all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ioctl_download  in  1  high for the duration of an HPS download.
REQ-006 ioctl_index  in  8  download index.
REQ-007 ioctl_wr  in  1  one-cycle byte strobe.
REQ-008 ioctl_addr  in  17  byte address.
REQ-009 ioctl_dout  in  8  byte data.
REQ-010 rom_addr  out  16  region-relative write address.
REQ-011 rom_data  out  8  write data.
REQ-012 main_we, snd_we, gfx_we, dec_we  out  1 each  one-cycle region write enables.
REQ-013 core_reset  out  1  hold game core in reset.
REQ-014 rom_loaded  out  1  last load passed the count check.
REQ-015 load_error  out  1  last load failed the count check.
REQ-016 checksum  out  8  modulo-256 sum of accepted in-map bytes of the last load.

Function
REQ-017 Region map (ioctl_addr): MAIN 0x00000-0x0FFFF; SND 0x10000-0x10FFF; GFX 0x11000-0x12FFF; DEC 0x13000-0x131FF; 0x13200 and above is out-of-map.
REQ-018 rom_addr SHALL equal ioctl_addr minus the region base, truncated to 16 bits.
REQ-019 States: IDLE, LOAD, CHECK, READY, ERROR.
REQ-020 IDLE/READY/ERROR -> LOAD when ioctl_download=1 and ioctl_index=ROM_INDEX; entering LOAD clears the byte counter, checksum, rom_loaded and load_error.
REQ-021 A download with any other index SHALL be ignored: no state change and no writes.
REQ-022 In LOAD, each ioctl_wr SHALL produce exactly one region write enable, one cycle later, with rom_addr/rom_data registered in the same cycle.
REQ-023 Out-of-map bytes SHALL produce no write enable and no checksum update, but SHALL be counted.
REQ-024 The 17-bit byte counter SHALL increment on every ioctl_wr in LOAD and saturate at 17'h1FFFF; duplicate addresses count again.
REQ-025 LOAD -> CHECK on the first cycle with ioctl_download=0. A write strobed in that same cycle SHALL be processed and counted before the check.
REQ-026 CHECK lasts one cycle, then goes to READY if count==EXP_BYTES (rom_loaded=1), else to ERROR (load_error=1).
REQ-027 core_reset=1 in IDLE, LOAD, CHECK and ERROR; core_reset=0 only in READY.
REQ-028 At most one write enable SHALL be high in any cycle; all write enables SHALL be 0 outside the cycle after an accepted strobe.

Reset
REQ-029 On reset: state=IDLE, all write enables=0, rom_addr=0, rom_data=0, counter=0, checksum=0, rom_loaded=0, load_error=0, core_reset=1.
REQ-030 Reset asserted mid-LOAD SHALL abort the load, and a write pending from the previous cycle SHALL be suppressed.

Structure
REQ-031 Region base/limit constants, EXP_BYTES and the state enum SHALL live in shared package williams2_rom_pkg.
REQ-032 Address decode SHALL be one combinational sub-module, rom_region_decode, with inputs addr and outputs region id and offset.
REQ-033 Target size is 120-400 lines of RTL; no RAM is instantiated inside this block.

Verification
REQ-034 Full load of 0x13200 bytes, data = addr[7:0] -> 0x10000 main_we, 0x1000 snd_we, 0x2000 gfx_we, 0x200 dec_we pulses; READY; rom_loaded=1; core_reset=0; checksum matches the model.
REQ-035 Byte at 0x11005=0xA5 -> gfx_we one cycle later with rom_addr=0x0005, rom_data=0xA5.
REQ-036 Load of 0x131FF bytes -> ERROR, load_error=1, core_reset stays 1; a following full load -> READY.
REQ-037 Last ioctl_wr in the same cycle as ioctl_download falling -> byte written and counted; READY.
REQ-038 Download with ioctl_index=1 -> no write enables and state unchanged; reset at byte 0x800 -> IDLE, no write enable on the next cycle.
REQ-039 Extra byte at 0x13200 in an otherwise full load -> no write enable, count=0x13201, ERROR.
